// File: rtl/nf10_wrr_input_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// nf10_wrr_arb_pkg
// Shared constants, FSM encoding and helper for the weighted round-robin
// input arbiter.
//   NUM_PORTS  number of ingress ports merged onto the egress stream
//   PTR_W      width of a port index / turn pointer
//   state_e    arbiter FSM encoding (IDLE = 0, PKT = 1)
//   next_port  modulo-NUM_PORTS increment of a port index
// ----------------------------------------------------------------------------
package nf10_wrr_arb_pkg;

   localparam int NUM_PORTS = 5;
   localparam int PTR_W     = 3;

   typedef enum logic {
      IDLE = 1'b0,
      PKT  = 1'b1
   } state_e;

   function automatic logic [PTR_W-1:0] next_port(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NUM_PORTS - 1)) ? '0 : p + PTR_W'(1);
   endfunction

endpackage

// File: rtl/nf10_wrr_input_arbiter_if.sv
// ----------------------------------------------------------------------------
// nf10_wrr_input_arbiter_if
// One AXI4-Stream link (payload plus valid/ready handshake).
//   master modport : drives tdata/tstrb/tuser/tvalid/tlast, receives tready
//   slave  modport : receives payload and tvalid, drives tready
// Parameters DATA_W / USER_W size tdata and tuser; tstrb is DATA_W/8 bits.
// ----------------------------------------------------------------------------
interface nf10_wrr_input_arbiter_if #(
   parameter int DATA_W = 256,
   parameter int USER_W = 128
) ();

   logic [DATA_W-1:0]   tdata;
   logic [DATA_W/8-1:0] tstrb;
   logic [USER_W-1:0]   tuser;
   logic                tvalid;
   logic                tready;
   logic                tlast;

   modport master (output tdata, output tstrb, output tuser,
                   output tvalid, output tlast, input tready);

   modport slave  (input tdata, input tstrb, input tuser,
                   input tvalid, input tlast, output tready);

endinterface

// File: rtl/nf10_wrr_input_arbiter_pick.sv
// ----------------------------------------------------------------------------
// nf10_rr_pick
// Combinational rotating-priority encoder. Scans req_i starting at start_i
// and wrapping modulo NUM_PORTS; reports the first requester found.
//   req_i    request vector, one bit per port
//   start_i  highest-priority port index for this scan (0..NUM_PORTS-1)
//   found_o  at least one request is set
//   idx_o    index of the selected requester (0 when found_o is low)
// ----------------------------------------------------------------------------
module nf10_rr_pick
   import nf10_wrr_arb_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [PTR_W-1:0]     start_i,
   output logic                 found_o,
   output logic [PTR_W-1:0]     idx_o
);

   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest requester after
   // start_i is the last (winning) assignment.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      found_o = 1'b0;
      idx_o   = '0;
      sum     = '0;
      cand    = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         sum = {1'b0, start_i} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(NUM_PORTS)) begin
            sum = sum - (PTR_W+1)'(NUM_PORTS);
         end
         cand = sum[PTR_W-1:0];
         if (req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/nf10_wrr_input_arbiter.sv
// ----------------------------------------------------------------------------
// nf10_wrr_input_arbiter
// Packet-granular weighted round-robin merge of five AXI4-Stream ingress
// ports onto one egress stream. A port keeps the turn for up to weight[i]
// consecutive packets; packets are never interleaved. One bubble cycle
// separates consecutive packets; beats inside a packet pass combinationally.
//   axi_aclk / axi_resetn  clock, asynchronous active-low reset
//   s_axis_0..s_axis_4     ingress streams (slave modport)
//   m_axis                 egress stream (master modport)
//   weights                packed per-port weights, port i at [i*W +: W];
//                          weight 0 disables the port
//   pkt_cnt                per-port forwarded-packet counters, port i at
//                          [i*32 +: 32]
// Build option: define NF10_WRR_ARB_STATS_EN to synthesize pkt_cnt; when
// undefined, pkt_cnt is tied to 0.
// ----------------------------------------------------------------------------
module nf10_wrr_input_arbiter
   import nf10_wrr_arb_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_WEIGHT_WIDTH       = 4
) (
   input  logic                                axi_aclk,
   input  logic                                axi_resetn,
   nf10_wrr_input_arbiter_if.slave             s_axis_0,
   nf10_wrr_input_arbiter_if.slave             s_axis_1,
   nf10_wrr_input_arbiter_if.slave             s_axis_2,
   nf10_wrr_input_arbiter_if.slave             s_axis_3,
   nf10_wrr_input_arbiter_if.slave             s_axis_4,
   nf10_wrr_input_arbiter_if.master            m_axis,
   input  logic [NUM_PORTS*C_WEIGHT_WIDTH-1:0] weights,
   output logic [NUM_PORTS*32-1:0]             pkt_cnt
);

   localparam int DW = C_M_AXIS_DATA_WIDTH;
   localparam int SW = C_M_AXIS_DATA_WIDTH / 8;
   localparam int UW = C_M_AXIS_TUSER_WIDTH;
   localparam int WW = C_WEIGHT_WIDTH;

   // Ingress ports flattened into arrays so the mux can index by grant.
   logic [DW-1:0]        in_tdata  [NUM_PORTS];
   logic [SW-1:0]        in_tstrb  [NUM_PORTS];
   logic [UW-1:0]        in_tuser  [NUM_PORTS];
   logic [NUM_PORTS-1:0] in_tvalid;
   logic [NUM_PORTS-1:0] in_tlast;
   logic [NUM_PORTS-1:0] in_tready;

   assign in_tdata[0] = s_axis_0.tdata;  assign in_tstrb[0] = s_axis_0.tstrb;
   assign in_tuser[0] = s_axis_0.tuser;  assign in_tvalid[0] = s_axis_0.tvalid;
   assign in_tlast[0] = s_axis_0.tlast;  assign s_axis_0.tready = in_tready[0];

   assign in_tdata[1] = s_axis_1.tdata;  assign in_tstrb[1] = s_axis_1.tstrb;
   assign in_tuser[1] = s_axis_1.tuser;  assign in_tvalid[1] = s_axis_1.tvalid;
   assign in_tlast[1] = s_axis_1.tlast;  assign s_axis_1.tready = in_tready[1];

   assign in_tdata[2] = s_axis_2.tdata;  assign in_tstrb[2] = s_axis_2.tstrb;
   assign in_tuser[2] = s_axis_2.tuser;  assign in_tvalid[2] = s_axis_2.tvalid;
   assign in_tlast[2] = s_axis_2.tlast;  assign s_axis_2.tready = in_tready[2];

   assign in_tdata[3] = s_axis_3.tdata;  assign in_tstrb[3] = s_axis_3.tstrb;
   assign in_tuser[3] = s_axis_3.tuser;  assign in_tvalid[3] = s_axis_3.tvalid;
   assign in_tlast[3] = s_axis_3.tlast;  assign s_axis_3.tready = in_tready[3];

   assign in_tdata[4] = s_axis_4.tdata;  assign in_tstrb[4] = s_axis_4.tstrb;
   assign in_tuser[4] = s_axis_4.tuser;  assign in_tvalid[4] = s_axis_4.tvalid;
   assign in_tlast[4] = s_axis_4.tlast;  assign s_axis_4.tready = in_tready[4];

   logic [WW-1:0]        weight [NUM_PORTS];
   logic [NUM_PORTS-1:0] eligible;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      assign weight[g]   = weights[g*WW +: WW];
      assign eligible[g] = in_tvalid[g] && (weight[g] != '0);
   end

   state_e           state_q, state_d;
   logic [PTR_W-1:0] ptr_q,   ptr_d;
   logic [PTR_W-1:0] grant_q, grant_d;
   logic [WW-1:0]    credit_q, credit_d;

   logic             pick_found;
   logic [PTR_W-1:0] pick_idx;

   nf10_rr_pick u_pick (
      .req_i   (eligible),
      .start_i (ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // Egress mux: outputs are all-zero outside PKT, so reset drops tvalid in
   // the same cycle and a truncated packet is simply abandoned.
   logic [DW-1:0] m_tdata;
   logic [SW-1:0] m_tstrb;
   logic [UW-1:0] m_tuser;
   logic          m_tvalid;
   logic          m_tlast;
   logic          hs_last;

   always_comb begin
      m_tdata   = '0;
      m_tstrb   = '0;
      m_tuser   = '0;
      m_tvalid  = 1'b0;
      m_tlast   = 1'b0;
      in_tready = '0;
      if (state_q == PKT) begin
         m_tdata             = in_tdata[grant_q];
         m_tstrb             = in_tstrb[grant_q];
         m_tuser             = in_tuser[grant_q];
         m_tvalid            = in_tvalid[grant_q];
         m_tlast             = in_tlast[grant_q];
         in_tready[grant_q]  = m_axis.tready;
      end
   end

   assign m_axis.tdata  = m_tdata;
   assign m_axis.tstrb  = m_tstrb;
   assign m_axis.tuser  = m_tuser;
   assign m_axis.tvalid = m_tvalid;
   assign m_axis.tlast  = m_tlast;

   assign hs_last = m_tvalid && m_axis.tready && m_tlast;

   // Next-state logic. Credit is sampled from the weights only when a fresh
   // turn starts, so weight changes land at the next turn boundary. A
   // pointer port that is not eligible is skipped by the scan and its
   // leftover credit is discarded by the reload.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      credit_d = credit_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               if (!((pick_idx == ptr_q) && (credit_q != '0))) begin
                  ptr_d    = pick_idx;
                  credit_d = weight[pick_idx];
               end
               state_d = PKT;
            end
         end
         PKT: begin
            if (hs_last) begin
               // Credit was loaded >= 1 at the turn start, so no underflow.
               credit_d = credit_q - WW'(1);
               if (credit_d == '0) begin
                  ptr_d = next_port(grant_q);
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         credit_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         credit_q <= credit_d;
      end
   end

`ifdef NF10_WRR_ARB_STATS_EN
   logic [31:0] cnt_q [NUM_PORTS];

   // NOTE: this register array is small and software-visible, so every
   // entry is reset explicitly; it is flops, not a RAM macro.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (hs_last) begin
         cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
      end
   end

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
      assign pkt_cnt[g*32 +: 32] = cnt_q[g];
   end
`else
   assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_nf10_wrr_input_arbiter.sv
// ----------------------------------------------------------------------------
// tb_nf10_wrr_input_arbiter
// Directed bench for the weighted round-robin input arbiter. Per-port packet
// sources drive the ingress links; a sampling task logs egress packets and
// flags interleaving, beat-order, payload and tlast errors. Each scenario
// task compares observations against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_nf10_wrr_input_arbiter;
   import nf10_wrr_arb_pkg::*;

   localparam int DW = 256;
   localparam int UW = 128;
   localparam int WW = 4;
   localparam int NP = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nf10_wrr_input_arbiter_if #(.DATA_W(DW), .USER_W(UW)) s0 ();
   nf10_wrr_input_arbiter_if #(.DATA_W(DW), .USER_W(UW)) s1 ();
   nf10_wrr_input_arbiter_if #(.DATA_W(DW), .USER_W(UW)) s2 ();
   nf10_wrr_input_arbiter_if #(.DATA_W(DW), .USER_W(UW)) s3 ();
   nf10_wrr_input_arbiter_if #(.DATA_W(DW), .USER_W(UW)) s4 ();
   nf10_wrr_input_arbiter_if #(.DATA_W(DW), .USER_W(UW)) m  ();

   logic [NP*WW-1:0] weights;
   logic [NP*32-1:0] pkt_cnt;

   // Source model state
   logic          src_on   [NP];
   bit            src_cont [NP];
   int            src_left [NP];
   int            src_len  [NP];
   int            src_beat [NP];
   int            src_seq  [NP];
   logic [DW-1:0] drv_tdata [NP];
   logic [UW-1:0] drv_tuser [NP];
   logic          drv_tlast [NP];
   logic [NP-1:0] tready_obs;
   logic          m_tready;
   bit            rand_ready;

   assign s0.tdata = drv_tdata[0]; assign s0.tstrb = '1; assign s0.tuser = drv_tuser[0];
   assign s0.tvalid = src_on[0];   assign s0.tlast = drv_tlast[0]; assign tready_obs[0] = s0.tready;
   assign s1.tdata = drv_tdata[1]; assign s1.tstrb = '1; assign s1.tuser = drv_tuser[1];
   assign s1.tvalid = src_on[1];   assign s1.tlast = drv_tlast[1]; assign tready_obs[1] = s1.tready;
   assign s2.tdata = drv_tdata[2]; assign s2.tstrb = '1; assign s2.tuser = drv_tuser[2];
   assign s2.tvalid = src_on[2];   assign s2.tlast = drv_tlast[2]; assign tready_obs[2] = s2.tready;
   assign s3.tdata = drv_tdata[3]; assign s3.tstrb = '1; assign s3.tuser = drv_tuser[3];
   assign s3.tvalid = src_on[3];   assign s3.tlast = drv_tlast[3]; assign tready_obs[3] = s3.tready;
   assign s4.tdata = drv_tdata[4]; assign s4.tstrb = '1; assign s4.tuser = drv_tuser[4];
   assign s4.tvalid = src_on[4];   assign s4.tlast = drv_tlast[4]; assign tready_obs[4] = s4.tready;
   assign m.tready = m_tready;

   nf10_wrr_input_arbiter #(
      .C_M_AXIS_DATA_WIDTH  (DW),
      .C_M_AXIS_TUSER_WIDTH (UW),
      .C_WEIGHT_WIDTH       (WW)
   ) dut (
      .axi_aclk   (clk),
      .axi_resetn (rst_n),
      .s_axis_0   (s0),
      .s_axis_1   (s1),
      .s_axis_2   (s2),
      .s_axis_3   (s3),
      .s_axis_4   (s4),
      .m_axis     (m),
      .weights    (weights),
      .pkt_cnt    (pkt_cnt)
   );

   // Egress monitor state
   typedef struct {
      int port;
      int first_cyc;
      int last_cyc;
      int nbeats;
   } pkt_t;

   pkt_t          pkts[$];
   pkt_t          cur;
   bit            in_pkt;
   int            exp_beat;
   int            order_err, interleave_err, payload_err, last_err;
   int            cyc;
   logic [NP-1:0] tready_seen;
   bit            mvalid_seen;
   bit            hs [NP];

   int checks = 0;
   int errors = 0;

`ifdef NF10_WRR_ARB_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   task automatic refresh();
      for (int i = 0; i < NP; i++) begin
         drv_tdata[i] = DW'({8'(i), 8'(src_seq[i]), 8'(src_beat[i])});
         drv_tuser[i] = UW'(8'(i) ^ 8'hA5);
         drv_tlast[i] = (src_beat[i] == src_len[i] - 1);
      end
   endtask

   task automatic start_src(input int i, input int len, input int npkts);
      src_on[i]   = 1'b1;
      src_cont[i] = (npkts == 0);
      src_left[i] = npkts;
      src_len[i]  = len;
      src_beat[i] = 0;
      refresh();
   endtask

   task automatic clear_mon();
      pkts.delete();
      in_pkt = 0; exp_beat = 0;
      order_err = 0; interleave_err = 0; payload_err = 0; last_err = 0;
      tready_seen = '0; mvalid_seen = 0;
      for (int i = 0; i < NP; i++) hs[i] = 0;
   endtask

   // Sample ingress handshakes and the egress beat away from the clock edge.
   task automatic sample();
      int p, b, nhs;
      @(negedge clk);
      tready_seen |= tready_obs;
      if (m.tvalid) mvalid_seen = 1;
      nhs = 0;
      for (int i = 0; i < NP; i++) begin
         hs[i] = src_on[i] && tready_obs[i];
         if (hs[i]) nhs++;
      end
      if (nhs > 1) interleave_err++;
      if (m.tvalid && m_tready) begin
         p = int'(m.tdata[23:16]);
         b = int'(m.tdata[7:0]);
         if (p >= NP) begin
            payload_err++;
         end else begin
            if (!hs[p]) payload_err++;
            if (m.tuser[7:0] !== (8'(p) ^ 8'hA5) || m.tstrb !== '1) payload_err++;
            if (m.tlast !== (b == src_len[p] - 1)) last_err++;
         end
         if (!in_pkt) begin
            cur = '{port: p, first_cyc: cyc, last_cyc: cyc, nbeats: 0};
            in_pkt = 1; exp_beat = 0;
         end else if (p != cur.port) begin
            interleave_err++;
         end
         if (b != exp_beat) order_err++;
         exp_beat++;
         cur.nbeats++;
         cur.last_cyc = cyc;
         if (m.tlast) begin
            pkts.push_back(cur);
            in_pkt = 0;
         end
      end
   endtask

   // Advance sources past the edge according to the sampled handshakes.
   task automatic advance();
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NP; i++) begin
         if (hs[i]) begin
            if (src_beat[i] == src_len[i] - 1) begin
               src_beat[i] = 0;
               src_seq[i]++;
               if (!src_cont[i]) begin
                  src_left[i]--;
                  if (src_left[i] == 0) src_on[i] = 1'b0;
               end
            end else begin
               src_beat[i]++;
            end
         end
         hs[i] = 0;
      end
      if (rand_ready) m_tready = 1'($urandom_range(0, 1));
      refresh();
   endtask

   task automatic cycle();
      sample();
      advance();
   endtask

   task automatic clear_src();
      for (int i = 0; i < NP; i++) begin
         src_on[i] = 1'b0; src_cont[i] = 0; src_left[i] = 0;
         src_len[i] = 1; src_beat[i] = 0; src_seq[i] = 0;
      end
      refresh();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_src();
      clear_mon();
      m_tready = 1'b1; rand_ready = 0;
      weights = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic run_until_pkts(input int n, input int budget, input string name);
      int k = 0;
      while (pkts.size() < n && k < budget) begin
         cycle();
         k++;
      end
      checks++;
      if (pkts.size() < n) begin
         errors++;
         $display("FAIL %s timeout: got %0d packets, required %0d", name, pkts.size(), n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_src();
      clear_mon();
      m_tready = 1'b1;
      weights = {NP{4'd1}};
      start_src(0, 2, 0);
      start_src(3, 2, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (m.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b required 0", m.tvalid); end
      checks++; if (tready_obs !== 5'b0) begin errors++; $display("FAIL reset_tready: got %b required 00000", tready_obs); end
      checks++; if (m.tdata !== '0 || m.tlast !== 1'b0 || m.tuser !== '0 || m.tstrb !== '0) begin
         errors++; $display("FAIL reset_payload: got tdata %0h tlast %b required all zero", m.tdata, m.tlast); end
      checks++; if (dut.state_q !== IDLE || dut.ptr_q !== 3'd0 || dut.credit_q !== 4'd0 || dut.grant_q !== 3'd0) begin
         errors++; $display("FAIL reset_state: got state %0d ptr %0d credit %0d grant %0d required 0 0 0 0",
                            dut.state_q, dut.ptr_q, dut.credit_q, dut.grant_q); end
      checks++; if (pkt_cnt !== '0) begin errors++; $display("FAIL reset_pkt_cnt: got %0h required 0", pkt_cnt); end
   endtask

   task automatic test_rr_equal();
      do_reset();
      weights = {NP{4'd1}};
      for (int i = 0; i < NP; i++) start_src(i, 2, 0);
      run_until_pkts(10, 200, "rr_equal");
      checks++; if (pkts.size() > 0 && pkts[0].first_cyc != 1) begin
         errors++; $display("FAIL rr_first_latency: got cycle %0d required 1", pkts[0].first_cyc); end
      for (int n = 0; n < 10 && n < pkts.size(); n++) begin
         checks++; if (pkts[n].port != n % NP || pkts[n].nbeats != 2) begin
            errors++; $display("FAIL rr_order[%0d]: got port %0d beats %0d required port %0d beats 2",
                               n, pkts[n].port, pkts[n].nbeats, n % NP); end
         if (n > 0) begin
            checks++; if (pkts[n].first_cyc - pkts[n-1].last_cyc != 2) begin
               errors++; $display("FAIL rr_bubble[%0d]: got spacing %0d required 2",
                                  n, pkts[n].first_cyc - pkts[n-1].last_cyc); end
         end
      end
      checks++; if (interleave_err + order_err + payload_err + last_err != 0) begin
         errors++; $display("FAIL rr_integrity: got interleave %0d order %0d payload %0d last %0d required 0",
                            interleave_err, order_err, payload_err, last_err); end
   endtask

   task automatic test_weighted();
      int exp_port [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
      do_reset();
      weights = {4'd0, 4'd0, 4'd0, 4'd1, 4'd3};
      for (int i = 0; i < NP; i++) start_src(i, 1, 0);
      run_until_pkts(8, 200, "weighted");
      for (int n = 0; n < 8 && n < pkts.size(); n++) begin
         checks++; if (pkts[n].port != exp_port[n]) begin
            errors++; $display("FAIL weighted_order[%0d]: got port %0d required %0d", n, pkts[n].port, exp_port[n]); end
      end
      checks++; if (tready_seen[4:2] !== 3'b000) begin
         errors++; $display("FAIL weighted_zero_tready: got %b required 000", tready_seen[4:2]); end
   endtask

   task automatic test_disabled();
      do_reset();
      weights = {4'd1, 4'd1, 4'd0, 4'd1, 4'd1};
      start_src(2, 1, 0);
      repeat (100) cycle();
      checks++; if (tready_seen !== 5'b0) begin errors++; $display("FAIL disabled_tready: got %b required 00000", tready_seen); end
      checks++; if (mvalid_seen || pkts.size() != 0) begin
         errors++; $display("FAIL disabled_egress: got tvalid_seen %0d packets %0d required 0 0", mvalid_seen, pkts.size()); end
   endtask

   task automatic test_forfeit();
      int exp_cnt = STATS;
      do_reset();
      weights = {4'd0, 4'd2, 4'd0, 4'd0, 4'd4};
      start_src(0, 2, 1);
      start_src(3, 2, 1);
      run_until_pkts(2, 50, "forfeit");
      repeat (4) cycle();
      checks++; if (pkts.size() != 2 || pkts[0].port != 0 || pkts[1].port != 3) begin
         errors++; $display("FAIL forfeit_order: got %0d packets first port %0d second port %0d required 2 0 3",
                            pkts.size(), pkts.size() > 0 ? pkts[0].port : -1, pkts.size() > 1 ? pkts[1].port : -1); end
      checks++; if (dut.ptr_q !== 3'd3 || dut.credit_q !== 4'd1) begin
         errors++; $display("FAIL forfeit_ptr: got ptr %0d credit %0d required 3 1", dut.ptr_q, dut.credit_q); end
      checks++; if (pkt_cnt[0 +: 32] != 32'(exp_cnt) || pkt_cnt[96 +: 32] != 32'(exp_cnt) ||
                    pkt_cnt[32 +: 32] != 32'd0) begin
         errors++; $display("FAIL forfeit_pkt_cnt: got p0 %0d p1 %0d p3 %0d required %0d 0 %0d",
                            pkt_cnt[0 +: 32], pkt_cnt[32 +: 32], pkt_cnt[96 +: 32], exp_cnt, exp_cnt); end
   endtask

   task automatic test_back_pressure();
      do_reset();
      weights = {4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
      start_src(0, 3, 0);
      start_src(2, 3, 0);
      start_src(1, 10, 1);
      rand_ready = 1;
      run_until_pkts(1, 300, "backpressure");
      rand_ready = 0;
      m_tready = 1'b1;
      checks++; if (pkts.size() < 1 || pkts[0].port != 1 || pkts[0].nbeats != 10) begin
         errors++; $display("FAIL bp_packet: got %0d packets beats %0d required 1 packet of 10 beats from port 1",
                            pkts.size(), pkts.size() > 0 ? pkts[0].nbeats : 0); end
      checks++; if (order_err != 0 || last_err != 0 || payload_err != 0) begin
         errors++; $display("FAIL bp_beats: got order %0d last %0d payload %0d required 0 0 0", order_err, last_err, payload_err); end
      checks++; if ((tready_seen & 5'b11101) !== 5'b0) begin
         errors++; $display("FAIL bp_other_tready: got %b required 00000", tready_seen & 5'b11101); end
   endtask

   task automatic test_reset_mid_packet();
      bit found = 0;
      do_reset();
      weights = {4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
      start_src(0, 6, 1);
      for (int k = 0; k < 30 && !found; k++) begin
         sample();
         if (m.tvalid && m.tdata[7:0] == 8'd2) found = 1;
         else advance();
      end
      checks++; if (!found) begin errors++; $display("FAIL midrst_timeout: got no beat 3 required beat 3 within 30 cycles"); end
      rst_n = 1'b0;
      #1;
      checks++; if (m.tvalid !== 1'b0 || tready_obs !== 5'b0) begin
         errors++; $display("FAIL midrst_drop: got tvalid %b tready %b required 0 00000", m.tvalid, tready_obs); end
      clear_src();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (dut.ptr_q !== 3'd0 || dut.state_q !== IDLE || m.tvalid !== 1'b0) begin
         errors++; $display("FAIL midrst_after: got ptr %0d state %0d tvalid %b required 0 0 0", dut.ptr_q, dut.state_q, m.tvalid); end
      checks++; if (pkt_cnt !== '0) begin errors++; $display("FAIL midrst_pkt_cnt: got %0h required 0", pkt_cnt); end
   endtask

   initial begin
      clear_src();
      clear_mon();
      m_tready = 1'b1;
      weights = '0;
      test_reset();
      test_rr_equal();
      test_weighted();
      test_disabled();
      test_forfeit();
      test_back_pressure();
      test_reset_mid_packet();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/nf10_wrr_input_arbiter.md
Name: nf10_wrr_input_arbiter

Overview:
- Packet-granular weighted round-robin arbiter that merges five AXI4-Stream ingress ports into one egress stream ahead of the output port lookup.
- Each port receives up to weight[i] consecutive packets per turn, then the turn passes to the next eligible port.
- Packets are never interleaved on the egress stream.
- Drop-in alternative to the plain round-robin input arbiter, with runtime-configurable weights from the register block.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, tdata width, egress and all ingress ports.
- C_M_AXIS_TUSER_WIDTH, 128, tuser width, egress and all ingress ports.
- C_WEIGHT_WIDTH, 4, bits per port weight.

Ports:
- axi_aclk  in  1  clock.
- axi_resetn  in  1  asynchronous active-low reset.
- s_axis_tdata_i  in  C_M_AXIS_DATA_WIDTH  ingress data, i=0..4.
- s_axis_tstrb_i  in  C_M_AXIS_DATA_WIDTH/8  byte strobes.
- s_axis_tuser_i  in  C_M_AXIS_TUSER_WIDTH  metadata.
- s_axis_tvalid_i  in  1  ingress valid.
- s_axis_tready_i  out  1  ingress ready.
- s_axis_tlast_i  in  1  end of packet.
- m_axis_tdata/tstrb/tuser/tlast  out  as ingress  egress beat.
- m_axis_tvalid  out  1  egress valid.
- m_axis_tready  in  1  egress ready.
- weights  in  5*C_WEIGHT_WIDTH  packed per-port weights; port i at [i*W +: W]. Weight 0 disables the port.
- pkt_cnt  out  5*32  per-port forwarded-packet counters (see Optional Feature).

Behaviour:
- Interface: one clock, axi_aclk. Reset axi_resetn is asynchronous, active-low.
- Reset values:
  - state=IDLE, ptr=0, credit=0, grant=0.
  - All s_axis_tready=0, m_axis_tvalid=0.
  - m_axis data, tstrb, tuser and tlast=0 (mux output with no grant).
- Eligibility: eligible[i] = s_axis_tvalid_i && weights[i]!=0.
- FSM state IDLE:
  - All treadys are 0.
  - If any port is eligible, pick the first eligible port scanning ptr, ptr+1, … mod 5; call it g.
  - If g==ptr and credit>0, keep credit.
  - Otherwise set ptr=g and credit=weights[g], sampled once here.
  - Register grant=g and go to PKT next cycle.
  - If no port is eligible, stay in IDLE.
- FSM state PKT:
  - Egress is a combinational mux of port grant.
  - m_axis_tvalid = s_axis_tvalid_grant.
  - s_axis_tready_grant = m_axis_tready; all other treadys are 0.
  - On a handshake with tlast=1: credit = credit-1. If the new credit is 0, ptr = (grant+1) mod 5. Return to IDLE.
- Latency: 1 cycle from tvalid to the first egress beat when idle. Exactly 1 bubble cycle between consecutive packets. Zero added latency per beat inside a packet.
- Weight changes take effect only at the next fresh turn. Lowering a weight to 0 mid-packet does not abort the packet.
- Turn forfeit: if ptr still has credit but ptr is not eligible in IDLE, the scan skips it and the remaining credit is forfeited.
- AXI compliance: tvalid and payload pass through unmodified. Upstream stability rules are preserved.
- Reset mid-packet: egress tvalid drops immediately and the truncated packet is not resumed. Downstream tolerates truncated packets on reset.
- ptr wrap: 4 -> 0.
- credit is a C_WEIGHT_WIDTH-bit down-counter and never underflows, since it is loaded ≥1 before any decrement.

Optional Feature:
- Macro NF10_WRR_ARB_STATS_EN.
- Defined:
  - pkt_cnt[i] increments on each tlast handshake from port i.
  - Wraps modulo 2^32; reset to 0.
- Undefined:
  - No counters are synthesized; pkt_cnt is tied to 0.
  - Port list is unchanged.

Decomposition:
- Package nf10_wrr_arb_pkg holds:
  - NUM_PORTS=5, PTR_W=3.
  - FSM state encoding: IDLE=0, PKT=1.
  - Function next_port(p) for mod-5 increment.
- One natural sub-module, nf10_rr_pick: combinational rotating-priority encoder.
  - Inputs: 5-bit request vector, 3-bit start pointer.
  - Outputs: found flag, 3-bit index.

Test Plan:
- Weights all 1; ports 0–4 each continuously offer 2-beat packets -> egress port order 0,1,2,3,4,0,…; one idle cycle between packets; no interleaving.
- weights={0:3,1:1,others 0}; ports 0 and 1 saturated -> pattern 0,0,0,1 repeating; ports 2–4 tready stays 0.
- Weight of port 2 = 0, port 2 valid alone -> never granted, s_axis_tready_2=0 for 100 cycles, m_axis_tvalid=0.
- Port 0 has weight 4, sends 1 packet then goes idle while port 3 is valid -> port 3 is granted next; port 0 credit is forfeited, ptr=3.
- m_axis_tready toggled randomly 50% during a 10-beat packet on port 1 -> all 10 beats delivered in order, tlast on beat 10 only, other ports' tready=0 throughout.
- axi_resetn asserted at beat 3 of a 6-beat packet -> same-cycle m_axis_tvalid=0, all tready=0; after release ptr=0, state IDLE; with the stats macro defined, pkt_cnt=0.
